lut3_vec_pipe: RTL

- Parametrised, pipelined successor to the team's fixed three-input gate function f = a·b + a·b'·c.
- Evaluates a programmable 3-input truth table bitwise across WIDTH lanes.
- Input and output use valid/ready handshakes with full back-pressure, through a STAGES-deep register pipeline.
- A saturating counter records output bit toggles between consecutive delivered results, which lets the lab bench check switching activity.

---
 rtl/lut3_pkg.sv | 28 ++
 rtl/lut3_vec_pipe_stage.sv | 40 ++++
 rtl/lut3_vec_pipe.sv | 115 +++++++++++
 3 files changed

// File: rtl/lut3_pkg.sv
// Shared types and helpers for the lut3_vec_pipe block.
// Truth-table indexing and popcount used by the datapath and toggle counter.
package lut3_pkg;

  localparam logic [7:0] LUT3_LEGACY = 8'hE0;
  localparam int POP_MAX_W = 64;

  function automatic logic [2:0] lut3_idx(
    input logic a,
    input logic b,
    input logic c
  );
    return {a, b, c};
  endfunction

  // Callers zero-extend narrower vectors; lanes above WIDTH add nothing.
  function automatic logic [6:0] popcount(
    input logic [POP_MAX_W-1:0] v
  );
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/lut3_vec_pipe_stage.sv
// One pipeline slot: valid bit plus data word.
// Loads from upstream whenever the slot is allowed to advance.
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv_i,
  input  logic         up_valid_i,
  input  logic [W-1:0] up_data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (adv_i) begin
      valid_d = up_valid_i;
      data_d  = up_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/lut3_vec_pipe.sv
// Programmable 3-input LUT applied per lane, with a back-pressured
// register pipeline and a saturating output-toggle counter.
module lut3_vec_pipe
  import lut3_pkg::*;
#(
  parameter int         WIDTH   = 8,
  parameter int         STAGES  = 2,
  parameter int         CNT_W   = 16,
  parameter logic [7:0] LUT_RST = LUT3_LEGACY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lut_we,
  input  logic [7:0]       lut_wdata,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_f,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int SUM_W = CNT_W + 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [7:0]       lut_q, lut_d;
  logic [WIDTH-1:0] f_eval;
  logic [STAGES:0]  vld;
  logic [WIDTH-1:0] dat [STAGES+1];
  logic [STAGES:1]  adv;

  always_comb begin
    lut_d = lut_q;
    if (lut_we) lut_d = lut_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lut_q <= LUT_RST;
    else     lut_q <= lut_d;
  end

  always_comb begin
    f_eval = '0;
    for (int i = 0; i < WIDTH; i++) begin
      f_eval[i] = lut_q[lut3_idx(in_a[i], in_b[i], in_c[i])];
    end
  end

  // A slot may move when everything downstream of it can move or it is empty.
  always_comb begin
    adv = '0;
    adv[STAGES] = out_ready | ~vld[STAGES];
    for (int k = STAGES - 1; k >= 1; k--) begin
      adv[k] = adv[k+1] | ~vld[k];
    end
  end

  assign vld[0]   = in_valid;
  assign dat[0]   = f_eval;
  assign in_ready = adv[1];

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    pipe_stage #(.W(WIDTH)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .adv_i      (adv[k]),
      .up_valid_i (vld[k-1]),
      .up_data_i  (dat[k-1]),
      .valid_o    (vld[k]),
      .data_o     (dat[k])
    );
  end

  assign out_valid = vld[STAGES];
  assign out_f     = dat[STAGES];

  logic             out_xfer;
  logic [WIDTH-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [6:0]       pc;
  logic [SUM_W-1:0] sum;

  assign out_xfer = out_valid & out_ready;

  // Clear lands first so a coincident transfer is still counted.
  always_comb begin
    pc       = popcount(POP_MAX_W'(out_f ^ last_q));
    cnt_base = cnt_clr ? '0 : cnt_q;
    sum      = SUM_W'(cnt_base) + SUM_W'(pc);
    cnt_d    = cnt_base;
    last_d   = last_q;
    if (out_xfer) begin
      last_d = out_f;
      if (sum > SUM_W'(CNT_MAX)) cnt_d = CNT_MAX;
      else                       cnt_d = sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  assign toggle_cnt = cnt_q;

endmodule
